// File: rtl/pews_bf16_pkg.sv
// Shared bf16 field constants, accumulator state encoding and a small
// leading-zero helper used by the adder's normalize step.
package pews_bf16_pkg;

  localparam int BF16_EXP_MSB = 14;
  localparam int BF16_EXP_LSB = 7;
  localparam int BF16_MAN_W   = 7;
  localparam logic [7:0] BF16_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // Leading zeros of an 8-bit significand; 8 when the value is zero.
  function automatic logic [3:0] lzc8(input logic [7:0] v);
    lzc8 = 4'd8;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) lzc8 = 4'(7 - k);
    end
  endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational bf16 adder: orders operands by magnitude, aligns, adds or
// subtracts and normalizes with truncation. No rounding, NaN or Inf handling;
// results that would underflow are flushed to zero.
module Addition_Subtraction
  import pews_bf16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result
);

  logic        w_aBig;
  logic [15:0] w_big;
  logic [15:0] w_small;
  logic [7:0]  w_bigExp;
  logic [7:0]  w_smallExp;
  logic [7:0]  w_bigMan;
  logic [7:0]  w_smallMan;
  logic [7:0]  w_expDiff;
  logic [7:0]  w_aligned;
  logic [8:0]  w_sum;
  logic [7:0]  w_diff;
  logic [7:0]  w_norm;
  logic [3:0]  w_lz;
  logic [7:0]  w_resExp;
  logic [6:0]  w_resMan;
  logic        w_resSign;
  logic        w_zero;

  // Align the smaller operand to the larger one and form the truncated sum.
  always_comb begin
    w_aBig     = (i_a[14:0] >= i_b[14:0]);
    w_big      = w_aBig ? i_a : i_b;
    w_small    = w_aBig ? i_b : i_a;
    w_bigExp   = w_big[BF16_EXP_MSB:BF16_EXP_LSB];
    w_smallExp = w_small[BF16_EXP_MSB:BF16_EXP_LSB];
    w_bigMan   = {(|w_bigExp), w_big[BF16_MAN_W-1:0]};
    w_smallMan = {(|w_smallExp), w_small[BF16_MAN_W-1:0]};
    w_expDiff  = w_bigExp - w_smallExp;
    w_aligned  = w_smallMan >> w_expDiff;
    w_sum      = {1'b0, w_bigMan} + {1'b0, w_aligned};
    w_diff     = w_bigMan - w_aligned;
    w_lz       = lzc8(w_diff);
    w_norm     = w_diff << w_lz;
    w_resSign  = w_big[15];
    w_resExp   = w_bigExp;
    w_resMan   = w_bigMan[6:0];
    w_zero     = 1'b0;
    if (i_a[15] == i_b[15]) begin
      if (w_sum[8]) begin
        w_resMan = w_sum[7:1];
        w_resExp = w_bigExp + 8'd1;
      end else begin
        w_resMan = w_sum[6:0];
      end
    end else begin
      if ((w_diff == 8'd0) || (w_bigExp <= {4'd0, w_lz})) begin
        w_zero = 1'b1;
      end else begin
        w_resMan = w_norm[6:0];
        w_resExp = w_bigExp - {4'd0, w_lz};
      end
    end
    o_result = w_zero ? 16'h0000 : {w_resSign, w_resExp, w_resMan};
  end

endmodule

// File: rtl/bf16_accumulator.sv
// Streaming bf16 vector reduction: sums operands one per cycle until the
// last flag, then presents the total with element count and overflow flag.
module bf16_accumulator
  import pews_bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_t       r_state;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [15:0]      w_sum;
  logic             w_accept;
  logic             w_inOvf;
  logic             w_sumOvf;

  Addition_Subtraction u_add (
    .i_a      (r_acc),
    .i_b      (in_data),
    .o_result (w_sum)
  );

  // Handshake decode; a held sum blocks input unless it drains this cycle.
  always_comb begin
    in_ready  = ~rst & ((r_state != HOLD) | out_ready);
    w_accept  = in_valid & in_ready;
    w_inOvf   = (in_data[BF16_EXP_MSB:BF16_EXP_LSB] == BF16_EXP_MAX);
    w_sumOvf  = (w_sum[BF16_EXP_MSB:BF16_EXP_LSB] == BF16_EXP_MAX);
    out_valid = (r_state == HOLD);
    out_data  = r_acc;
    out_count = r_cnt;
    out_ovf   = r_ovf;
  end

  // Vector FSM; the first element is loaded directly so a signed zero survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= 16'h0000;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_cnt   <= CNT_ONE;
            r_ovf   <= w_inOvf;
            r_state <= in_last ? HOLD : ACCUM;
          end else if (r_state == HOLD && out_ready) begin
            r_state <= IDLE;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_cnt   <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
            r_ovf   <= r_ovf | w_sumOvf;
            r_state <= in_last ? HOLD : ACCUM;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
